// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: transmitter FSM states and serial frame constants.
package uartUtil;

    typedef enum logic [1:0] {
        IDLE,
        START,
        SEND,
        STOP
    } states_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_transmitter_fifo.sv
// Circular byte buffer feeding the transmitter; the read word is visible combinationally.
module uart_tx_fifo
    import uartUtil::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] pushData,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] popData,
    output logic                 empty,
    output logic                 full
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wrPtr_q;
    logic [PTR_W-1:0]     rdPtr_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic                 doPush;
    logic                 doPop;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign popData = mem_q[rdPtr_q];

    always_comb begin
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + CNT_W'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit stage: queues bytes through a valid/ready FIFO and sends 8N1 frames back to back.
module uart_transmitter
    import uartUtil::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] txData,
    input  logic                 txValid,
    output logic                 txReady,
    output logic                 transmitterOutput,
    output logic                 busy
);

    localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    states_t              state_q;
    logic [15:0]          tick_q;
    logic [2:0]           bitIndex_q;
    logic [DATA_BITS-1:0] shiftReg_q;
    logic                 line_q;

    logic                 bitDone;
    logic                 pop;
    logic                 fifoEmpty;
    logic                 fifoFull;
    logic [DATA_BITS-1:0] popData;

    uart_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (txValid),
        .pushData(txData),
        .pop     (pop),
        .popData (popData),
        .empty   (fifoEmpty),
        .full    (fifoFull)
    );

    assign bitDone           = (tick_q == LAST_TICK);
    assign pop               = !fifoEmpty && ((state_q == IDLE) || ((state_q == STOP) && bitDone));
    assign txReady           = !fifoFull;
    assign busy              = (state_q != IDLE);
    assign transmitterOutput = line_q;

    // The line flop is loaded with the level of the state/bit being entered, so it never glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bitIndex_q <= '0;
            shiftReg_q <= '0;
            line_q     <= STOP_BIT;
        end else begin
            case (state_q)
                IDLE: begin
                    tick_q <= '0;
                    line_q <= STOP_BIT;
                    if (!fifoEmpty) begin
                        shiftReg_q <= popData;
                        state_q    <= START;
                        line_q     <= START_BIT;
                    end
                end
                START: begin
                    if (bitDone) begin
                        tick_q     <= '0;
                        bitIndex_q <= '0;
                        state_q    <= SEND;
                        line_q     <= shiftReg_q[0];
                    end else begin
                        tick_q <= tick_q + 16'd1;
                    end
                end
                SEND: begin
                    if (bitDone) begin
                        tick_q     <= '0;
                        shiftReg_q <= shiftReg_q >> 1;
                        if (bitIndex_q == LAST_BIT) begin
                            state_q <= STOP;
                            line_q  <= STOP_BIT;
                        end else begin
                            bitIndex_q <= bitIndex_q + 3'd1;
                            line_q     <= shiftReg_q[1];
                        end
                    end else begin
                        tick_q <= tick_q + 16'd1;
                    end
                end
                STOP: begin
                    if (bitDone) begin
                        tick_q <= '0;
                        if (!fifoEmpty) begin
                            shiftReg_q <= popData;
                            state_q    <= START;
                            line_q     <= START_BIT;
                        end else begin
                            state_q <= IDLE;
                            line_q  <= STOP_BIT;
                        end
                    end else begin
                        tick_q <= tick_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tick_q  <= '0;
                    line_q  <= STOP_BIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: one instance at one clock per bit, one at four clocks per bit.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] txData1;
    logic       txValid1;
    logic       txReady1;
    logic       line1;
    logic       busy1;
    logic [7:0] txData4;
    logic       txValid4;
    logic       txReady4;
    logic       line4;
    logic       busy4;

    int compared   = 0;
    int mismatched = 0;

    logic [0:9]  frameA5;
    logic [0:19] frameBackToBack;
    logic [0:9]  frame81;
    logic [7:0]  fullBytes [6];
    logic        lineLog [70];
    logic        readyLog [70];
    logic        readyPrev;
    int          accepted;
    int          base;
    logic [7:0]  rxByte;

    always #5 clk = ~clk;

    uart_transmitter #(
        .CLKS_PER_BIT(1),
        .FIFO_DEPTH  (4)
    ) dut1 (
        .clk              (clk),
        .rst              (rst),
        .txData           (txData1),
        .txValid          (txValid1),
        .txReady          (txReady1),
        .transmitterOutput(line1),
        .busy             (busy1)
    );

    uart_transmitter #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (4)
    ) dut4 (
        .clk              (clk),
        .rst              (rst),
        .txData           (txData4),
        .txValid          (txValid4),
        .txReady          (txReady4),
        .transmitterOutput(line4),
        .busy             (busy4)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data);
        txData1  = data;
        txValid1 = 1'b1;
        @(negedge clk);
        txValid1 = 1'b0;
    endtask

    initial begin
        frameA5         = 10'b0101001011;
        frameBackToBack = 20'b0_00000000_1_0_11111111_1;
        frame81         = 10'b0100000011;
        fullBytes       = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        // Reset held with a valid byte offered: nothing may be captured.
        rst      = 1'b0;
        txData1  = 8'h77;
        txValid1 = 1'b1;
        txData4  = 8'h00;
        txValid4 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset line", 8'(line1), 8'h1);
        checkOutput("reset busy", 8'(busy1), 8'h0);
        checkOutput("reset ready", 8'(txReady1), 8'h1);
        checkOutput("reset line cpb4", 8'(line4), 8'h1);
        txValid1 = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post-reset idle line %0d", i), 8'(line1), 8'h1);
            checkOutput($sformatf("post-reset idle busy %0d", i), 8'(busy1), 8'h0);
        end

        $display("[TB] single byte A5");
        applyStimulus(8'hA5);
        checkOutput("A5 before start", 8'(line1), 8'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("A5 bit %0d", i), 8'(line1), 8'(frameA5[i]));
            checkOutput($sformatf("A5 busy %0d", i), 8'(busy1), 8'h1);
        end
        @(negedge clk);
        checkOutput("A5 idle line", 8'(line1), 8'h1);
        checkOutput("A5 idle busy", 8'(busy1), 8'h0);

        $display("[TB] back-to-back 00 FF");
        txData1  = 8'h00;
        txValid1 = 1'b1;
        @(negedge clk);
        txData1 = 8'hFF;
        @(negedge clk);
        txValid1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput($sformatf("b2b bit %0d", i), 8'(line1), 8'(frameBackToBack[i]));
            checkOutput($sformatf("b2b busy %0d", i), 8'(busy1), 8'h1);
        end
        @(negedge clk);
        checkOutput("b2b idle line", 8'(line1), 8'h1);
        checkOutput("b2b idle busy", 8'(busy1), 8'h0);

        $display("[TB] full FIFO with txValid held");
        accepted  = 0;
        txData1   = fullBytes[0];
        txValid1  = 1'b1;
        readyPrev = txReady1;
        for (int c = 1; c < 70; c++) begin
            @(negedge clk);
            lineLog[c]  = line1;
            readyLog[c] = txReady1;
            if (txValid1 && readyPrev) accepted++;
            if (accepted < 6) begin
                txData1 = fullBytes[accepted];
            end else begin
                txValid1 = 1'b0;
            end
            readyPrev = txReady1;
        end
        checkOutput("full accepted count", 8'(accepted), 8'd6);
        checkOutput("full ready c4", 8'(readyLog[4]), 8'h1);
        checkOutput("full ready c5", 8'(readyLog[5]), 8'h0);
        checkOutput("full ready c11", 8'(readyLog[11]), 8'h0);
        checkOutput("full ready c12", 8'(readyLog[12]), 8'h1);
        checkOutput("full ready c13", 8'(readyLog[13]), 8'h0);
        checkOutput("full ready c21", 8'(readyLog[21]), 8'h0);
        checkOutput("full ready c22", 8'(readyLog[22]), 8'h1);
        for (int f = 0; f < 6; f++) begin
            base = 2 + 10 * f;
            for (int b = 0; b < 8; b++) rxByte[b] = lineLog[base + 1 + b];
            checkOutput($sformatf("full frame %0d start", f), 8'(lineLog[base]), 8'h0);
            checkOutput($sformatf("full frame %0d data", f), rxByte, fullBytes[f]);
            checkOutput($sformatf("full frame %0d stop", f), 8'(lineLog[base + 9]), 8'h1);
        end
        checkOutput("full idle line", 8'(lineLog[65]), 8'h1);
        checkOutput("full idle busy", 8'(busy1), 8'h0);

        $display("[TB] four clocks per bit, byte 81");
        txData4  = 8'h81;
        txValid4 = 1'b1;
        @(negedge clk);
        txValid4 = 1'b0;
        checkOutput("81 before start", 8'(line4), 8'h1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checkOutput($sformatf("81 cycle %0d", i), 8'(line4), 8'(frame81[i / 4]));
            checkOutput($sformatf("81 busy %0d", i), 8'(busy4), 8'h1);
        end
        @(negedge clk);
        checkOutput("81 idle line", 8'(line4), 8'h1);
        checkOutput("81 idle busy", 8'(busy4), 8'h0);

        $display("[TB] reset mid-frame");
        txData1  = 8'h3C;
        txValid1 = 1'b1;
        @(negedge clk);
        txData1 = 8'h5A;
        @(negedge clk);
        txData1 = 8'hC3;
        @(negedge clk);
        txValid1 = 1'b0;
        @(negedge clk);
        checkOutput("3C bit1", 8'(line1), 8'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("3C bit3", 8'(line1), 8'h1);
        checkOutput("3C busy", 8'(busy1), 8'h1);
        #1 rst = 1'b0;
        #1;
        checkOutput("async reset line", 8'(line1), 8'h1);
        checkOutput("async reset busy", 8'(busy1), 8'h0);
        checkOutput("async reset ready", 8'(txReady1), 8'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            checkOutput($sformatf("flushed line %0d", i), 8'(line1), 8'h1);
            checkOutput($sformatf("flushed busy %0d", i), 8'(busy1), 8'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
